// File: rtl/top_processor_pmp.sv
// Single-cycle RV32I-subset core with PMP-checked fetch and data access.
// Define PMP_DATA_HALT_EN to make data faults halt the core as well.
module top_processor_pmp #(
  parameter int PMP_ENTRIES = 4,
  parameter int IMEM_WORDS  = 64,
  parameter int DMEM_WORDS  = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic [7:0] PC_Out,
  output logic       instr_pmp_ok,
  output logic       data_pmp_ok,
  output logic       instr_exec_violation,
  output logic       data_read_violation,
  output logic       data_write_violation,
  output logic       PMP_Violation_Detected
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // TOR ranges [lo,hi), perms packed as {R,W,X}
  localparam logic [8:0] PMP_LO [4] = '{9'h000, 9'h040, 9'h080, 9'h0C0};
  localparam logic [8:0] PMP_HI [4] = '{9'h040, 9'h080, 9'h0C0, 9'h100};
  localparam logic [2:0] PMP_RWX [4] = '{3'b101, 3'b110, 3'b000, 3'b110};

  function automatic logic [2:0] pmp_perm(input logic [7:0] a);
    logic [2:0] p;
    logic       hit;
    p   = 3'b000;
    hit = 1'b0;
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      if (!hit && ({1'b0, a} >= PMP_LO[i]) && ({1'b0, a} < PMP_HI[i])) begin
        hit = 1'b1;
        p   = PMP_RWX[i];
      end
    end
    return p;
  endfunction

  logic [7:0]  pc_q, pc_d;
  logic        halt_q, halt_d;
  logic [31:0] rf_q [1:31];
  logic [31:0] rf_d [1:31];
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [31:0] rom [IMEM_WORDS];

  always_comb begin
    for (int i = 0; i < IMEM_WORDS; i++) rom[i] = NOP;
    rom[0] = 32'h0440_0093;
    rom[1] = 32'h0070_0113;
    rom[2] = 32'h0020_A023;
    rom[3] = 32'h0000_A183;
    rom[4] = 32'h0800_0213;
    rom[5] = 32'h0002_2283;
    rom[6] = 32'h0400_0313;
    rom[7] = 32'h0003_0067;
  end

  logic [31:0] instr;
  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, rs1_val, rs2_val;
  logic [7:0]  imm_s8, imm_b8, imm_j8, ea_ld, ea_st, ea;
  logic [2:0]  fetch_perm, ea_perm;
  logic        exec_fault;
  logic        is_addi, is_alu, is_lw, is_sw, is_beq, is_jal, is_jalr;

  assign instr  = rom[pc_q[7:2]];
  assign opc    = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s8 = {instr[27:25], instr[11:7]};
  assign imm_b8 = {instr[27:25], instr[11:8], 1'b0};
  assign imm_j8 = {instr[27:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
  assign is_alu  = (opc == 7'b0110011) && (f3 == 3'b000) &&
                   ((f7 == 7'h00) || (f7 == 7'h20));
  assign is_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
  assign is_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
  assign is_beq  = (opc == 7'b1100011) && (f3 == 3'b000);
  assign is_jal  = (opc == 7'b1101111);
  assign is_jalr = (opc == 7'b1100111) && (f3 == 3'b000);

  assign ea_ld   = rs1_val[7:0] + imm_i[7:0];
  assign ea_st   = rs1_val[7:0] + imm_s8;
  assign ea      = is_sw ? ea_st : ea_ld;
  assign ea_perm = pmp_perm(ea);

  assign fetch_perm = pmp_perm(pc_q);
  assign exec_fault = halt_q | ~fetch_perm[0];

  logic        rd_we;
  logic [31:0] rd_val;
  logic        dmem_we;
  logic        rd_viol, wr_viol;

  always_comb begin
    rf_d    = rf_q;
    pc_d    = pc_q;
    halt_d  = halt_q;
    rd_we   = 1'b0;
    rd_val  = 32'd0;
    dmem_we = 1'b0;
    rd_viol = 1'b0;
    wr_viol = 1'b0;
    if (exec_fault) begin
      halt_d = 1'b1;
    end else begin
      pc_d = pc_q + 8'd4;
      unique case (1'b1)
        is_addi: begin
          rd_we  = 1'b1;
          rd_val = rs1_val + imm_i;
        end
        is_alu: begin
          rd_we  = 1'b1;
          rd_val = f7[5] ? rs1_val - rs2_val : rs1_val + rs2_val;
        end
        is_lw: begin
          if (ea_perm[2]) begin
            rd_we  = 1'b1;
            rd_val = dmem_q[ea[7:2]];
          end else begin
            rd_viol = 1'b1;
          end
        end
        is_sw: begin
          if (ea_perm[1]) dmem_we = 1'b1;
          else wr_viol = 1'b1;
        end
        is_beq: begin
          if (rs1_val == rs2_val) pc_d = pc_q + imm_b8;
        end
        is_jal: begin
          rd_we  = 1'b1;
          rd_val = {24'd0, pc_q + 8'd4};
          pc_d   = pc_q + imm_j8;
        end
        is_jalr: begin
          rd_we  = 1'b1;
          rd_val = {24'd0, pc_q + 8'd4};
          pc_d   = ea_ld & 8'hFE;
        end
        default: ;
      endcase
      if (rd_we && (rd != 5'd0)) rf_d[rd] = rd_val;
`ifdef PMP_DATA_HALT_EN
      if (rd_viol || wr_viol) halt_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q   <= 8'd0;
      halt_q <= 1'b0;
      for (int i = 1; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
      rf_q   <= rf_d;
    end
  end

  // Data RAM keeps its contents across reset
  always_ff @(posedge Clock) begin
    if (dmem_we) dmem_q[ea[7:2]] <= rs2_val;
  end

  assign PC_Out                 = pc_q;
  assign instr_pmp_ok           = ~exec_fault;
  assign instr_exec_violation   = exec_fault;
  assign data_read_violation    = rd_viol;
  assign data_write_violation   = wr_viol;
  assign data_pmp_ok            = ~(rd_viol | wr_viol);
  assign PMP_Violation_Detected = exec_fault | rd_viol | wr_viol;

endmodule

// File: tb/tb_top_processor_pmp.sv
// Bench for top_processor_pmp: ISA-level program model with PMP ranges,
// randomized reset timing, per-cycle comparison of all status ports.
module tb_top_processor_pmp;

  logic       Clock;
  logic       Reset;
  logic [7:0] PC_Out;
  logic       instr_pmp_ok, data_pmp_ok;
  logic       instr_exec_violation;
  logic       data_read_violation, data_write_violation;
  logic       PMP_Violation_Detected;

  top_processor_pmp dut (
    .Clock                 (Clock),
    .Reset                 (Reset),
    .PC_Out                (PC_Out),
    .instr_pmp_ok          (instr_pmp_ok),
    .data_pmp_ok           (data_pmp_ok),
    .instr_exec_violation  (instr_exec_violation),
    .data_read_violation   (data_read_violation),
    .data_write_violation  (data_write_violation),
    .PMP_Violation_Detected(PMP_Violation_Detected)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef enum int {M_NOP, M_ADDI, M_LW, M_SW, M_JALR} op_e;
  op_e p_op [8];
  int  p_rd [8], p_rs1 [8], p_rs2 [8], p_imm [8];

  int unsigned mregs [32];
  int unsigned mmem [64];
  logic [7:0]  mpc;
  bit          mhalt;

  int m_rd_cnt, m_wr_cnt, m_ex_cnt;
  int o_rd_cnt, o_wr_cnt, o_ex_cnt, o_data_after_halt;

  function automatic void set_op(int i, op_e o, int d, int s1, int s2, int im);
    p_op[i] = o; p_rd[i] = d; p_rs1[i] = s1; p_rs2[i] = s2; p_imm[i] = im;
  endfunction

  function automatic void load_prog();
    set_op(0, M_ADDI, 1, 0, 0, 'h44);
    set_op(1, M_ADDI, 2, 0, 0, 7);
    set_op(2, M_SW,   0, 1, 2, 0);
    set_op(3, M_LW,   3, 1, 0, 0);
    set_op(4, M_ADDI, 4, 0, 0, 'h80);
    set_op(5, M_LW,   5, 4, 0, 0);
    set_op(6, M_ADDI, 6, 0, 0, 'h40);
    set_op(7, M_JALR, 0, 6, 0, 0);
    for (int i = 0; i < 64; i++) mmem[i] = 0;
  endfunction

  function automatic bit can_r(logic [7:0] a);
    return (a < 8'h80) || (a >= 8'hC0);
  endfunction
  function automatic bit can_w(logic [7:0] a);
    return (a >= 8'h40 && a < 8'h80) || (a >= 8'hC0);
  endfunction
  function automatic bit can_x(logic [7:0] a);
    return a < 8'h40;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 0;
    mpc = 8'h00;
    mhalt = 1'b0;
  endfunction

  function automatic op_e cur_op(output int idx);
    idx = int'(mpc[7:2]);
    if (idx < 8) return p_op[idx];
    return M_NOP;
  endfunction

  function automatic logic [7:0] data_addr(int idx);
    int unsigned s;
    s = mregs[p_rs1[idx]] + p_imm[idx];
    return s[7:0];
  endfunction

  function automatic void model_expect(output logic ex, output logic rv,
                                       output logic wv);
    int  idx;
    op_e o;
    ex = mhalt || !can_x(mpc);
    rv = 1'b0;
    wv = 1'b0;
    if (!ex) begin
      o = cur_op(idx);
      if (o == M_LW) rv = !can_r(data_addr(idx));
      if (o == M_SW) wv = !can_w(data_addr(idx));
    end
  endfunction

  function automatic void model_step();
    logic ex, rv, wv;
    int   idx;
    op_e  o;
    logic [7:0] a;
    int unsigned s;
    model_expect(ex, rv, wv);
    if (ex) begin
      mhalt = 1'b1;
      return;
    end
    o = cur_op(idx);
    a = 8'h00;
    if (o == M_LW || o == M_SW || o == M_JALR) a = data_addr(idx);
    case (o)
      M_ADDI: begin
        s = mregs[p_rs1[idx]] + p_imm[idx];
        if (p_rd[idx] != 0) mregs[p_rd[idx]] = s;
      end
      M_LW: if (!rv && p_rd[idx] != 0) mregs[p_rd[idx]] = mmem[a[7:2]];
      M_SW: if (!wv) mmem[a[7:2]] = mregs[p_rs2[idx]];
      default: ;
    endcase
    if (o == M_JALR) begin
      if (p_rd[idx] != 0) mregs[p_rd[idx]] = {24'd0, mpc + 8'd4};
      mpc = a & 8'hFE;
    end else begin
      mpc = mpc + 8'd4;
    end
`ifdef PMP_DATA_HALT_EN
    if (rv || wv) mhalt = 1'b1;
`endif
  endfunction

  task automatic test_reset();
    Reset = 1'b0;
    model_reset();
    load_prog();
    repeat (5) @(negedge Clock);
    n_cmp++;
    if (PC_Out !== 8'h00) begin
      n_err++;
      $display("FAIL reset_pc got %h exp 00", PC_Out);
    end
    n_cmp++;
    if (PMP_Violation_Detected !== 1'b0) begin
      n_err++;
      $display("FAIL reset_viol got %b exp 0", PMP_Violation_Detected);
    end
    n_cmp++;
    if (instr_pmp_ok !== 1'b1) begin
      n_err++;
      $display("FAIL reset_iok got %b exp 1", instr_pmp_ok);
    end
    n_cmp++;
    if (data_pmp_ok !== 1'b1) begin
      n_err++;
      $display("FAIL reset_dok got %b exp 1", data_pmp_ok);
    end
    Reset = 1'b1;
    #1;
  endtask

  task automatic test_run(input int ncyc);
    logic ex, rv, wv, prev_ex;
    m_rd_cnt = 0; m_wr_cnt = 0; m_ex_cnt = 0;
    o_rd_cnt = 0; o_wr_cnt = 0; o_ex_cnt = 0; o_data_after_halt = 0;
    prev_ex = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      model_expect(ex, rv, wv);
      m_rd_cnt += int'(rv);
      m_wr_cnt += int'(wv);
      if (ex && !prev_ex) m_ex_cnt++;
      prev_ex = ex;
      n_cmp++;
      if (PC_Out !== mpc) begin
        n_err++;
        $display("FAIL run_pc cyc%0d got %h exp %h", c, PC_Out, mpc);
      end
      n_cmp++;
      if (instr_exec_violation !== ex || instr_pmp_ok !== !ex) begin
        n_err++;
        $display("FAIL run_exec cyc%0d got x%b ok%b exp x%b", c,
                 instr_exec_violation, instr_pmp_ok, ex);
      end
      n_cmp++;
      if (data_read_violation !== rv || data_write_violation !== wv) begin
        n_err++;
        $display("FAIL run_data cyc%0d got r%b w%b exp r%b w%b", c,
                 data_read_violation, data_write_violation, rv, wv);
      end
      n_cmp++;
      if (data_pmp_ok !== !(rv || wv) ||
          PMP_Violation_Detected !== (ex || rv || wv)) begin
        n_err++;
        $display("FAIL run_ok cyc%0d got dok%b v%b", c, data_pmp_ok,
                 PMP_Violation_Detected);
      end
      o_rd_cnt += int'(data_read_violation === 1'b1);
      o_wr_cnt += int'(data_write_violation === 1'b1);
      if (instr_exec_violation === 1'b1 && !(c > 0 && o_ex_cnt > 0))
        o_ex_cnt++;
      if (instr_exec_violation === 1'b1 &&
          (data_read_violation === 1'b1 || data_write_violation === 1'b1))
        o_data_after_halt++;
      model_step();
      @(negedge Clock);
      #1;
    end
  endtask

  task automatic test_fault_counts();
    n_cmp++;
    if (o_rd_cnt !== m_rd_cnt || o_wr_cnt !== m_wr_cnt ||
        o_ex_cnt !== m_ex_cnt) begin
      n_err++;
      $display("FAIL fault_counts got r%0d w%0d x%0d exp r%0d w%0d x%0d",
               o_rd_cnt, o_wr_cnt, o_ex_cnt, m_rd_cnt, m_wr_cnt, m_ex_cnt);
    end
    n_cmp++;
    if (o_data_after_halt !== 0) begin
      n_err++;
      $display("FAIL data_after_halt got %0d exp 0", o_data_after_halt);
    end
`ifndef PMP_DATA_HALT_EN
    n_cmp++;
    if (o_rd_cnt !== 1 || o_wr_cnt !== 0 || o_ex_cnt !== 1) begin
      n_err++;
      $display("FAIL run_totals got r%0d w%0d x%0d exp r1 w0 x1",
               o_rd_cnt, o_wr_cnt, o_ex_cnt);
    end
    n_cmp++;
    if (PC_Out !== 8'h40) begin
      n_err++;
      $display("FAIL halt_pc got %h exp 40", PC_Out);
    end
    n_cmp++;
    if (dut.rf_q[3] !== 32'd7) begin
      n_err++;
      $display("FAIL x3_load got %h exp 7", dut.rf_q[3]);
    end
`endif
    n_cmp++;
    if (dut.rf_q[3] !== mregs[3] || dut.rf_q[5] !== mregs[5]) begin
      n_err++;
      $display("FAIL regs got x3=%h x5=%h exp x3=%h x5=%h",
               dut.rf_q[3], dut.rf_q[5], mregs[3], mregs[5]);
    end
  endtask

  task automatic test_async_reset();
    int hold;
    #($urandom_range(1, 3));
    Reset = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (PC_Out !== 8'h00 || instr_exec_violation !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got pc%h x%b exp pc00 x0", PC_Out,
               instr_exec_violation);
    end
    n_cmp++;
    if (PMP_Violation_Detected !== 1'b0 || instr_pmp_ok !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_flags got v%b ok%b exp v0 ok1",
               PMP_Violation_Detected, instr_pmp_ok);
    end
    hold = $urandom_range(1, 4);
    repeat (hold) @(negedge Clock);
    Reset = 1'b1;
    #1;
  endtask

  task automatic test_midrun_reset();
    test_run($urandom_range(2, 7));
    test_async_reset();
  endtask

  initial begin
    test_reset();
    test_run(140);
    test_fault_counts();
    test_async_reset();
    test_run(30);
    test_fault_counts();
    test_midrun_reset();
    test_run(40);
    test_fault_counts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
